// File: rtl/nack_seq_gap_detector.sv
// PSN gap detector: pops received PSNs from an FWFT FIFO, emits a NACK for each forward gap.
// Optional statistics counters are built only when NACK_GEN_STATS_EN is defined.
module nack_seq_gap_detector #(
    parameter int PSN_W   = 16,
    parameter int MAX_GAP = 256,
    parameter int CNT_W   = 32
) (
    input  logic             wr_clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic             fifo_rd_rst_busy,
    input  logic [PSN_W-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             nack_valid,
    input  logic             nack_ready,
    output logic [PSN_W-1:0] nack_psn,
    output logic [PSN_W-1:0] nack_len,
    output logic             synced,
    output logic [CNT_W-1:0] nack_cnt,
    output logic [CNT_W-1:0] dup_cnt,
    output logic [CNT_W-1:0] resync_cnt
);

    typedef enum logic [1:0] {INIT, RUN, EMIT} state_t;

    localparam logic [PSN_W-1:0] MAX_GAP_P = PSN_W'(MAX_GAP);
    localparam logic [PSN_W-1:0] HALF_P    = PSN_W'(1) << (PSN_W - 1);
    localparam logic [PSN_W-1:0] ONE_P     = PSN_W'(1);

    state_t           state_q, state_d;
    logic [PSN_W-1:0] expected_q, expected_d;
    logic             synced_q, synced_d;
    logic             nack_valid_q, nack_valid_d;
    logic [PSN_W-1:0] nack_psn_q, nack_psn_d;
    logic [PSN_W-1:0] nack_len_q, nack_len_d;

    logic [PSN_W-1:0] gap;
    logic             run_pop;
    logic             cls_inorder, cls_nack, cls_resync, cls_dup;

    assign fifo_rd_en = !fifo_empty && !fifo_rd_rst_busy && (state_q != EMIT);
    assign run_pop    = fifo_rd_en && (state_q == RUN);

    // Modulo difference: values at or above half the PSN space lie behind expected.
    assign gap         = fifo_dout - expected_q;
    assign cls_inorder = (gap == '0);
    assign cls_nack    = !cls_inorder && (gap <= MAX_GAP_P);
    assign cls_resync  = (gap > MAX_GAP_P) && (gap < HALF_P);
    assign cls_dup     = (gap >= HALF_P);

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        synced_d     = synced_q;
        nack_valid_d = nack_valid_q;
        nack_psn_d   = nack_psn_q;
        nack_len_d   = nack_len_q;
        case (state_q)
            INIT: begin
                if (fifo_rd_en) begin
                    expected_d = fifo_dout + ONE_P;
                    synced_d   = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (run_pop) begin
                    if (cls_inorder) begin
                        expected_d = expected_q + ONE_P;
                    end else if (cls_nack) begin
                        nack_psn_d   = expected_q;
                        nack_len_d   = gap;
                        nack_valid_d = 1'b1;
                        expected_d   = fifo_dout + ONE_P;
                        state_d      = EMIT;
                    end else if (cls_resync) begin
                        expected_d = fifo_dout + ONE_P;
                    end
                end
            end
            EMIT: begin
                if (nack_ready) begin
                    nack_valid_d = 1'b0;
                    state_d      = RUN;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            expected_q   <= '0;
            synced_q     <= 1'b0;
            nack_valid_q <= 1'b0;
            nack_psn_q   <= '0;
            nack_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            synced_q     <= synced_d;
            nack_valid_q <= nack_valid_d;
            nack_psn_q   <= nack_psn_d;
            nack_len_q   <= nack_len_d;
        end
    end

    assign nack_valid = nack_valid_q;
    assign nack_psn   = nack_psn_q;
    assign nack_len   = nack_len_q;
    assign synced     = synced_q;

`ifdef NACK_GEN_STATS_EN
    logic [CNT_W-1:0] nack_cnt_q, nack_cnt_d;
    logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic [CNT_W-1:0] resync_cnt_q, resync_cnt_d;

    // Saturating increments: stop at all-ones rather than wrapping.
    always_comb begin
        nack_cnt_d   = nack_cnt_q;
        dup_cnt_d    = dup_cnt_q;
        resync_cnt_d = resync_cnt_q;
        if (run_pop && cls_nack && (nack_cnt_q != '1))
            nack_cnt_d = nack_cnt_q + CNT_W'(1);
        if (run_pop && cls_dup && (dup_cnt_q != '1))
            dup_cnt_d = dup_cnt_q + CNT_W'(1);
        if (run_pop && cls_resync && (resync_cnt_q != '1))
            resync_cnt_d = resync_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            nack_cnt_q   <= '0;
            dup_cnt_q    <= '0;
            resync_cnt_q <= '0;
        end else begin
            nack_cnt_q   <= nack_cnt_d;
            dup_cnt_q    <= dup_cnt_d;
            resync_cnt_q <= resync_cnt_d;
        end
    end

    assign nack_cnt   = nack_cnt_q;
    assign dup_cnt    = dup_cnt_q;
    assign resync_cnt = resync_cnt_q;
`else
    assign nack_cnt   = '0;
    assign dup_cnt    = '0;
    assign resync_cnt = '0;
`endif

endmodule

// File: doc/nack_seq_gap_detector.md
# nack_seq_gap_detector

- Sits directly downstream of the 16-bit, 2048-deep FWFT sync FIFO that buffers received packet sequence numbers (PSNs) in the NACK generator.
- Pops one PSN per cycle and compares it against the expected PSN, using modulo-2^PSN_W arithmetic.
- For each forward gap, emits a NACK request (first missing PSN, missing count) on a valid/ready interface to the NACK packet builder.
- Discards duplicate/stale PSNs and resynchronises on implausibly large jumps.

## Interface
Parameters:
- PSN_W, 16, PSN width; equals the FIFO READ_DATA_WIDTH.
- MAX_GAP, 256, largest gap reported as a NACK; must satisfy 1 ≤ MAX_GAP < 2^(PSN_W-1).
- CNT_W, 32, width of the statistics counters.

Ports:
- wr_clk  in  1  sole clock (same clock as the FIFO).
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag (FWFT).
- fifo_rd_rst_busy  in  1  FIFO read-side reset busy; no pops while high.
- fifo_dout  in  PSN_W  head-of-FIFO PSN, valid whenever !fifo_empty.
- fifo_rd_en  out  1  pop strobe (combinational).
- nack_valid  out  1  NACK request valid.
- nack_ready  in  1  downstream accepts the request.
- nack_psn  out  PSN_W  first missing PSN.
- nack_len  out  PSN_W  number of missing PSNs (1..MAX_GAP).
- synced  out  1  expected PSN has been established.
- nack_cnt, dup_cnt, resync_cnt  out  CNT_W each  statistics (see Configuration).

## Operation
- State machine: INIT, RUN, EMIT.
- Reset values:
  - state = INIT; expected = 0; synced = 0.
  - nack_valid = 0; nack_psn = 0; nack_len = 0.
  - All counters = 0.
- Pop rule:
  - fifo_rd_en = !fifo_empty && !fifo_rd_rst_busy && (state != EMIT).
  - A pop consumes fifo_dout in that same cycle.
- INIT, on pop:
  - expected ← fifo_dout + 1; synced ← 1; go to RUN.
  - No NACK is emitted.
- RUN, on pop: compute gap = (fifo_dout − expected) mod 2^PSN_W, as a PSN_W-bit unsigned difference. Then:
  - gap == 0: in order. expected ← expected + 1.
  - 1 ≤ gap ≤ MAX_GAP: register nack_psn ← expected and nack_len ← gap; set nack_valid ← 1; expected ← fifo_dout + 1; nack_cnt++; go to EMIT.
  - MAX_GAP < gap < 2^(PSN_W-1): resync. expected ← fifo_dout + 1; resync_cnt++; no NACK.
  - gap ≥ 2^(PSN_W-1): duplicate/stale (behind expected). Discard; expected unchanged; dup_cnt++.
- EMIT:
  - nack_valid held high; nack_psn/nack_len stable until nack_valid && nack_ready.
  - On the handshake: nack_valid ← 0; go to RUN.
  - No pops occur in EMIT.
- All PSN arithmetic wraps modulo 2^PSN_W. Example: expected 0xFFFF, pop 0x0002 → gap 3, nack_psn 0xFFFF, nack_len 3, expected 0x0003.
- Counters saturate at 2^CNT_W − 1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending NACK is dropped. The block re-enters INIT and resyncs on the next PSN.

## Timing
- Pop → nack_valid: 1 cycle (registered).
- Pop → expected update: 1 cycle.
- Gapless throughput: one PSN per cycle, back-to-back, while !fifo_empty.
- Throughput with gaps: each NACK costs at least 1 EMIT cycle, plus one cycle per cycle nack_ready is low.
- nack_ready high in the first EMIT cycle: handshake completes; RUN (with popping) resumes the following cycle.
- fifo_empty and fifo_rd_rst_busy are sampled combinationally each cycle. No pop is issued in a cycle where either is high.
- Counters update in the cycle after the classifying pop.

## Configuration
- Macro NACK_GEN_STATS_EN.
- Defined: nack_cnt, dup_cnt and resync_cnt are implemented as saturating CNT_W-bit registers.
- Undefined: counter registers are omitted and the three outputs are tied to 0. Classification, NACK emission and resync behaviour are identical.

## Test plan
- **In-order stream.** Reset; push PSNs 0x0010..0x0013 → four pops on consecutive cycles; no nack_valid; synced=1 after the first pop; expected ends at 0x0014.
- **Gap with backpressure.** After syncing at 0x0010, push 0x0011 then 0x0015; hold nack_ready=0 for 3 cycles → nack_psn=0x0012 and nack_len=3, held stable; no pops until the handshake; then 0x0016 is accepted in order.
- **Wrap-around.** Sync at 0xFFFE; push 0x0001 → nack_psn=0xFFFF, nack_len=2; a following 0x0002 is in order.
- **Duplicate and resync.** Expected 0x0100: push 0x00F0 → dup_cnt=1, no NACK. Then push 0x0300 (gap 0x200 > MAX_GAP) → resync_cnt=1, no NACK, expected 0x0301.
- **Reset during EMIT.** Assert rst while nack_valid=1 → nack_valid=0 and synced=0 immediately. After release, the next PSN 0x0050 syncs with no NACK.
- **Macro off.** Build without NACK_GEN_STATS_EN and rerun the duplicate/resync scenario → identical NACK/pop behaviour; all counter outputs read 0.
